mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/mem_port_arbiter_rr.sv | 21 ++
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, owner encoding
// and default bus widths.
package mem_port_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WR1,
        ST_WR2,
        ST_DONE
    } state_t;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_IO  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// Two-input round-robin selector: a lone requester wins, a tie goes to the
// port that was not served last. Grant is one-hot, bit 0 = CPU, bit 1 = IO.
module rr_arbiter2
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = '0;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == OWNER_IO) ? 2'b01 : 2'b10;
            default: gnt = '0;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a CPU port and an IO/loader port onto one single-port RAM;
// every access is latched in IDLE and all outputs come straight from flops.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_done,

    input  logic              io_req,
    input  logic              io_we,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic              io_gnt,
    output logic              io_done,

    output logic [DATA_W-1:0] rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_q
);

    state_t            state, next_state;
    owner_t            owner_q, last_q, sel_owner, next_owner;
    logic [1:0]        rr_gnt;
    logic              accept, sel_we, busy;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              cpu_gnt_d, io_gnt_d, cpu_done_d, io_done_d, mem_we_d;

    rr_arbiter2 u_rr (
        .req  ({io_req, cpu_req}),
        .last (last_q),
        .gnt  (rr_gnt)
    );

    always_comb begin
        sel_owner = rr_gnt[1] ? OWNER_IO : OWNER_CPU;
        sel_we    = rr_gnt[1] ? io_we    : cpu_we;
        sel_addr  = rr_gnt[1] ? io_addr  : cpu_addr;
        sel_wdata = rr_gnt[1] ? io_wdata : cpu_wdata;
        accept    = (state == ST_IDLE) && (rr_gnt != 2'b00);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: if (accept) next_state = sel_we ? ST_WR1 : ST_READ;
            ST_READ: next_state = ST_DONE;
            ST_WR1:  next_state = ST_WR2;
            ST_WR2:  next_state = ST_DONE;
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so they can be registered
    // and still line up with the state they describe.
    always_comb begin
        next_owner = accept ? sel_owner : owner_q;
        busy       = (next_state != ST_IDLE);
        cpu_gnt_d  = busy && (next_owner == OWNER_CPU);
        io_gnt_d   = busy && (next_owner == OWNER_IO);
        cpu_done_d = (next_state == ST_DONE) && (next_owner == OWNER_CPU);
        io_done_d  = (next_state == ST_DONE) && (next_owner == OWNER_IO);
        mem_we_d   = (next_state == ST_WR1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cpu_gnt   <= 1'b0;
            io_gnt    <= 1'b0;
            cpu_done  <= 1'b0;
            io_done   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
            owner_q   <= OWNER_CPU;
            last_q    <= OWNER_IO;
        end else begin
            cpu_gnt  <= cpu_gnt_d;
            io_gnt   <= io_gnt_d;
            cpu_done <= cpu_done_d;
            io_done  <= io_done_d;
            mem_we   <= mem_we_d;
            if (accept) begin
                owner_q   <= sel_owner;
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
            end
            if (state == ST_READ) begin
                rdata <= mem_q;
            end
            if (state == ST_DONE) begin
                last_q <= owner_q;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter with a behavioural RAM
// and a transaction-level reference of arbitration order and memory contents.
module tb_mem_port_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, io_req, io_we;
    logic [AW-1:0] cpu_addr, io_addr, mem_addr;
    logic [DW-1:0] cpu_wdata, io_wdata, mem_wdata, mem_q, rdata;
    logic          cpu_gnt, cpu_done, io_gnt, io_done, mem_we;

    logic [DW-1:0] ram     [256];
    logic [DW-1:0] ref_mem [256];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit last_io;

    typedef struct {
        bit            port;
        bit            rd;
        logic [DW-1:0] data;
    } exp_t;
    exp_t expq[$];
    exp_t e;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock     (clock),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_gnt   (cpu_gnt),
        .cpu_done  (cpu_done),
        .io_req    (io_req),
        .io_we     (io_we),
        .io_addr   (io_addr),
        .io_wdata  (io_wdata),
        .io_gnt    (io_gnt),
        .io_done   (io_done),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_q     (mem_q)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc++;
    end

    always @(posedge clock) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
    end

    assign mem_q = ram[mem_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_access(input bit port, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t x;
        x.port = port;
        x.rd   = !we;
        x.data = ref_mem[a];
        if (we) ref_mem[a] = d;
        expq.push_back(x);
    endtask

    // Invariant checks and scoreboard pop, sampled on the falling edge.
    logic          p_we, p_cg, p_ig, p_cd, p_id;
    logic [AW-1:0] p_addr;
    always @(negedge clock) begin
        if (reset) begin
            p_we = 0; p_cg = 0; p_ig = 0; p_cd = 0; p_id = 0; p_addr = '0;
        end else begin
            check("gnt_exclusive", {31'd0, cpu_gnt & io_gnt}, 32'd0);
            if (mem_we)
                check("we_only_in_wr1", {31'd0, (cpu_gnt & !p_cg) | (io_gnt & !p_ig)}, 32'd1);
            if (p_we) begin
                check("we_one_cycle", {31'd0, mem_we}, 32'd0);
                check("addr_held_wr2", {24'd0, mem_addr}, {24'd0, p_addr});
            end
            if (p_cd) check("cpu_done_width", {31'd0, cpu_done}, 32'd0);
            if (p_id) check("io_done_width", {31'd0, io_done}, 32'd0);
            if (cpu_done || io_done) begin
                if (expq.size() == 0) begin
                    check("unexpected_done", {30'd0, cpu_done, io_done}, 32'd0);
                end else begin
                    e = expq.pop_front();
                    check("done_port", {30'd0, cpu_done, io_done}, e.port ? 32'd1 : 32'd2);
                    if (e.rd) check("rdata", {16'd0, rdata}, {16'd0, e.data});
                end
            end
            p_we = mem_we; p_addr = mem_addr;
            p_cg = cpu_gnt; p_ig = io_gnt; p_cd = cpu_done; p_id = io_done;
        end
    end

    // Entered and left on a falling edge with the arbiter idle.
    task automatic do_round(input bit uc, input bit cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                            input bit ui, input bit iw, input logic [AW-1:0] ia, input logic [DW-1:0] id,
                            input bit scr, input bit drop);
        bit first_io, fc, fi;
        int start, dc, di, gc, gi, lc, li;
        lc = cw ? 3 : 2;
        li = iw ? 3 : 2;
        first_io = 0;
        if (uc && ui) begin
            first_io = !last_io;
            if (first_io) begin
                model_access(1, iw, ia, id); model_access(0, cw, ca, cd); last_io = 0;
            end else begin
                model_access(0, cw, ca, cd); model_access(1, iw, ia, id); last_io = 1;
            end
        end else if (uc) begin
            model_access(0, cw, ca, cd); last_io = 0;
        end else if (ui) begin
            model_access(1, iw, ia, id); last_io = 1;
        end
        cpu_req = uc; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        io_req  = ui; io_we  = iw; io_addr  = ia; io_wdata  = id;
        start = cyc; fc = !uc; fi = !ui; dc = 0; di = 0; gc = -1; gi = -1;
        for (int n = 0; n < 40 && !(fc && fi); n++) begin
            @(negedge clock);
            if (cpu_gnt && gc < 0) gc = cyc;
            if (io_gnt && gi < 0) gi = cyc;
            if (cpu_done) begin
                fc = 1; dc = cyc; cpu_req = 0;
            end else if (cpu_gnt) begin
                if (scr) begin cpu_addr = cpu_addr + 1'b1; cpu_wdata = ~cpu_wdata; cpu_we = ~cpu_we; end
                if (drop) cpu_req = 0;
            end
            if (io_done) begin
                fi = 1; di = cyc; io_req = 0;
            end else if (io_gnt) begin
                if (scr) begin io_addr = io_addr + 1'b1; io_wdata = ~io_wdata; io_we = ~io_we; end
                if (drop) io_req = 0;
            end
        end
        cpu_req = 0; io_req = 0;
        check("round_completes", {30'd0, fc, fi}, 32'd3);
        if (uc && ui) begin
            if (first_io) begin
                check("lat_first_io", 32'(di - start), 32'(li));
                check("lat_second_cpu", 32'(dc - di), 32'(1 + lc));
            end else begin
                check("lat_first_cpu", 32'(dc - start), 32'(lc));
                check("lat_second_io", 32'(di - dc), 32'(1 + li));
            end
        end else if (uc) begin
            check("cpu_gnt_lat", 32'(gc - start), 32'd1);
            check("lat_cpu", 32'(dc - start), 32'(lc));
        end else if (ui) begin
            check("io_gnt_lat", 32'(gi - start), 32'd1);
            check("lat_io", 32'(di - start), 32'(li));
        end
        @(negedge clock);
    endtask

    task automatic apply_reset();
        reset = 1;
        cpu_req = 0; io_req = 0;
        repeat (2) @(negedge clock);
        reset = 0;
        last_io = 1;
        @(negedge clock);
    endtask

    initial begin
        logic [AW-1:0] a;
        for (int i = 0; i < 256; i++) begin
            ram[i] = DW'($urandom);
            ref_mem[i] = ram[i];
        end
        ram[8'h05] = 16'h1234;        ref_mem[8'h05] = 16'h1234;
        ram[8'h11] = ~ram[8'h10];     ref_mem[8'h11] = ram[8'h11];

        cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        io_we  = 0; io_addr  = '0; io_wdata  = '0;
        reset = 1; cpu_req = 0; io_req = 0; last_io = 1;
        repeat (2) @(negedge clock);
        check("rst_gnt", {30'd0, cpu_gnt, io_gnt}, 32'd0);
        check("rst_done", {30'd0, cpu_done, io_done}, 32'd0);
        check("rst_mem", {7'd0, mem_we, mem_addr, mem_wdata}, 32'd0);
        check("rst_rdata", {16'd0, rdata}, 32'd0);
        reset = 0;
        @(negedge clock);
        check("idle_after_rst", {29'd0, cpu_gnt, io_gnt, mem_we}, 32'd0);

        do_round(1, 0, 8'h05, 16'h0, 0, 0, 8'h0, 16'h0, 0, 0);
        check("cpu_read_0x05", {16'd0, rdata}, 32'h1234);
        do_round(0, 0, 8'h0, 16'h0, 1, 1, 8'h20, 16'hBEEF, 0, 0);
        do_round(1, 0, 8'h20, 16'h0, 0, 0, 8'h0, 16'h0, 0, 0);
        check("readback_0x20", {16'd0, rdata}, 32'hBEEF);

        apply_reset();
        for (int r = 0; r < 4; r++)
            do_round(1, r[0], 8'h30 + 8'(r), 16'hA000 + 16'(r), 1, !r[0], 8'h30 + 8'(r), 16'hB000 + 16'(r), 0, 0);

        do_round(1, 0, 8'h10, 16'h0, 0, 0, 8'h0, 16'h0, 1, 0);
        do_round(1, 1, 8'h40, 16'h4444, 0, 0, 8'h0, 16'h0, 0, 1);
        do_round(0, 0, 8'h0, 16'h0, 1, 1, 8'h41, 16'h5555, 1, 1);
        do_round(0, 0, 8'h0, 16'h0, 1, 0, 8'h40, 16'h0, 0, 0);

        // Reset in the middle of a write: no RAM update, no done pulse.
        a = 8'h50;
        cpu_req = 1; cpu_we = 1; cpu_addr = a; cpu_wdata = ~ref_mem[a];
        @(negedge clock);
        check("wr1_we_high", {30'd0, mem_we, cpu_gnt}, 32'd3);
        #2 reset = 1;
        #1;
        check("async_rst_we_gnt", {29'd0, mem_we, cpu_gnt, io_gnt}, 32'd0);
        check("async_rst_addr", {24'd0, mem_addr}, 32'd0);
        cpu_req = 0;
        repeat (2) @(negedge clock);
        reset = 0;
        last_io = 1;
        @(negedge clock);
        do_round(1, 0, a, 16'h0, 0, 0, 8'h0, 16'h0, 0, 0);

        for (int r = 0; r < 60; r++) begin
            int mode;
            mode = $urandom_range(0, 2);
            do_round(mode != 1, 1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom),
                     mode != 0, 1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom),
                     1'($urandom), 1'($urandom));
        end

        repeat (4) @(negedge clock);
        check("queue_drained", 32'(expq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
